// File: rtl/ddio_rx_checker_if.sv
// ddio_rx_checker_if: word/status bundle between one DDIO receive lane and its checker.
//   word_in   captured word: [15:14] flag, [13:4] message, [3:0] CRC
//   alert_clr clears the sticky CRC alert
//   wr_en/wr_addr/wr_data  receive RAM write port
//   busy, burst_done, frame_cnt, err_cnt, overflow, timeout, crc_alert  burst status
// master = word source / status consumer, slave = checker.
interface ddio_rx_checker_if #(parameter int W = 16);
   logic [W-1:0] word_in;
   logic         alert_clr;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic         busy;
   logic         burst_done;
   logic [4:0]   frame_cnt;
   logic [4:0]   err_cnt;
   logic         overflow;
   logic         timeout;
   logic         crc_alert;
   modport master (
      output word_in, alert_clr,
      input  wr_en, wr_addr, wr_data, busy, burst_done, frame_cnt, err_cnt, overflow, timeout, crc_alert
   );
   modport slave (
      input  word_in, alert_clr,
      output wr_en, wr_addr, wr_data, busy, burst_done, frame_cnt, err_cnt, overflow, timeout, crc_alert
   );
endinterface

// File: rtl/ddio_rx_checker.sv
// ddio_rx_checker: per-lane receive frame checker; verifies CRC-4 of each word,
// stores frame words into the lane's half of the receive RAM and reports burst status.
//   clk  receive clock
//   rst  asynchronous active-high reset
//   bus  slave side of ddio_rx_checker_if (word in, RAM write port, burst status out)
module ddio_rx_checker #(
   parameter int                MESS_LEN  = 10,
   parameter int                CRC_LEN   = 4,
   parameter logic [CRC_LEN:0]  POLY      = 5'b10111,
   parameter logic [4:0]        ADDR_INIT = 5'b00000,
   parameter int                DEPTH     = 16,
   parameter int                TIMEOUT   = 8
) (
   input logic             clk,
   input logic             rst,
   ddio_rx_checker_if.slave bus
);
   localparam int W  = MESS_LEN + CRC_LEN + 2;
   localparam int IW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
   state_t          state, state_d;
   logic [4:0]      addr, f0, e0, a0;
   logic [IW-1:0]   idle_q, idle_d;
   logic [1:0]      flag;
   logic            start, proc, is_frame, full, store, bad, err_inc, idle_hit, to_hit;
   // Remainder of msg * x^CRC_LEN mod POLY by bitwise long division.
   function automatic logic [CRC_LEN-1:0] crc_f(input logic [MESS_LEN-1:0] m);
      logic [MESS_LEN+CRC_LEN-1:0] r;
      r = {m, {CRC_LEN{1'b0}}};
      for (int i = MESS_LEN + CRC_LEN - 1; i >= CRC_LEN; i--)
         if (r[i]) r[i -: CRC_LEN+1] = r[i -: CRC_LEN+1] ^ POLY;
      return r[CRC_LEN-1:0];
   endfunction
   assign flag = bus.word_in[W-1 -: 2];
   always_comb begin
      start    = state == IDLE && flag != 2'b00;
      proc     = start || (state == RECV && flag != 2'b00);
      // A starting burst processes its first word against freshly cleared counters.
      f0       = start ? 5'd0 : bus.frame_cnt;
      e0       = start ? 5'd0 : bus.err_cnt;
      a0       = start ? ADDR_INIT : addr;
      is_frame = proc && flag[0];
      full     = f0 == 5'(DEPTH);
      store    = is_frame && !full;
      bad      = is_frame && crc_f(bus.word_in[W-3 -: MESS_LEN]) != bus.word_in[CRC_LEN-1:0];
      err_inc  = bad || (proc && flag == 2'b10);
      idle_hit = state == RECV && flag == 2'b00;
      idle_d   = idle_hit ? idle_q + 1'b1 : '0;
      to_hit   = idle_hit && idle_d == IW'(TIMEOUT);
      state_d  = state == DONE ? IDLE :
                 ((proc && flag == 2'b11) || to_hit) ? DONE :
                 start ? RECV : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idle_q         <= '0;
         addr           <= ADDR_INIT;
         bus.wr_en      <= 1'b0;
         bus.wr_addr    <= '0;
         bus.wr_data    <= '0;
         bus.busy       <= 1'b0;
         bus.burst_done <= 1'b0;
         bus.frame_cnt  <= '0;
         bus.err_cnt    <= '0;
         bus.overflow   <= 1'b0;
         bus.timeout    <= 1'b0;
         bus.crc_alert  <= 1'b0;
      end else begin
         state          <= state_d;
         idle_q         <= idle_d;
         addr           <= a0 + 5'(store);
         bus.wr_en      <= store;
         if (store) bus.wr_addr <= a0;
         if (store) bus.wr_data <= bus.word_in;
         bus.busy       <= state_d == RECV;
         // Registered from DONE so the pulse lands one cycle after the closing word.
         bus.burst_done <= state == DONE;
         bus.frame_cnt  <= f0 + 5'(store);
         bus.err_cnt    <= e0 + 5'(err_inc && e0 != 5'd31);
         bus.overflow   <= (start ? 1'b0 : bus.overflow) | (is_frame && full);
         bus.timeout    <= (start ? 1'b0 : bus.timeout) | to_hit;
         bus.crc_alert  <= bad | (bus.crc_alert & ~bus.alert_clr);
      end
   end
endmodule

// File: tb/tb_ddio_rx_checker.sv
// tb_ddio_rx_checker: table-driven bench for ddio_rx_checker; two lanes (ADDR_INIT 0 and 16)
// see the same words, per-cycle status comes from the table, RAM writes from a scoreboard.
module tb_ddio_rx_checker;
   typedef struct {
      logic [15:0] w;
      logic        c;
      logic        wr;
      logic [4:0]  ad;
      logic [15:0] st;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] word = '0;
   logic        clr = 1'b0;
   int          tests = 0;
   int          fails = 0;
   int          row = 0;
   vec_t        tbl[$];
   logic [20:0] qa[$];
   logic [20:0] qb[$];
   always #5 clk = ~clk;
   ddio_rx_checker_if ia();
   ddio_rx_checker_if ib();
   assign ia.word_in   = word;
   assign ib.word_in   = word;
   assign ia.alert_clr = clr;
   assign ib.alert_clr = clr;
   ddio_rx_checker #(.ADDR_INIT(5'b00000)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   ddio_rx_checker #(.ADDR_INIT(5'b10000)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   wire [15:0] st_a = {ia.wr_en, ia.busy, ia.burst_done, ia.frame_cnt, ia.err_cnt, ia.crc_alert, ia.overflow, ia.timeout};
   wire [15:0] st_b = {ib.wr_en, ib.busy, ib.burst_done, ib.frame_cnt, ib.err_cnt, ib.crc_alert, ib.overflow, ib.timeout};
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask
   // Status packing: {wr_en, busy, burst_done, frame_cnt, err_cnt, crc_alert, overflow, timeout}
   function automatic void add(input logic [15:0] w, input logic c, input logic wr, input logic [4:0] ad,
                               input logic bu, input logic dn, input logic [4:0] fr, input logic [4:0] er,
                               input logic al, input logic ov, input logic to);
      tbl.push_back('{w, c, wr, ad, {wr, bu, dn, fr, er, al, ov, to}});
   endfunction
   task automatic run();
      foreach (tbl[i]) begin
         word = tbl[i].w;
         clr  = tbl[i].c;
         if (tbl[i].wr) begin
            qa.push_back({tbl[i].ad, tbl[i].w});
            qb.push_back({tbl[i].ad | 5'h10, tbl[i].w});
         end
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("row%0d_a", row), 32'(st_a), 32'(tbl[i].st));
         chk($sformatf("row%0d_b", row), 32'(st_b), 32'(tbl[i].st));
         row++;
      end
      tbl.delete();
      clr = 1'b0;
   endtask
   always @(negedge clk) begin
      if (!rst && ia.wr_en) begin
         if (qa.size() == 0) chk("wr_a_extra", 32'(ia.wr_en), 32'd0);
         else chk("wr_a", {11'd0, ia.wr_addr, ia.wr_data}, 32'(qa.pop_front()));
      end
      if (!rst && ib.wr_en) begin
         if (qb.size() == 0) chk("wr_b_extra", 32'(ib.wr_en), 32'd0);
         else chk("wr_b", {11'd0, ib.wr_addr, ib.wr_data}, 32'(qb.pop_front()));
      end
   end
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_st_a", 32'(st_a), 32'd0);
      chk("reset_st_b", 32'(st_b), 32'd0);
      chk("reset_addr_b", 32'(ib.wr_addr), 32'd0);
      // clean burst
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'h402E, 0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
      add(16'hC02E, 0, 1, 2, 0, 0, 3, 0, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
      // bad CRC, sticky alert, then cleared
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'h4018, 0, 1, 1, 1, 0, 2, 1, 1, 0, 0);
      add(16'hC02E, 0, 1, 2, 0, 0, 3, 1, 1, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 3, 1, 1, 0, 0);
      add(16'h0000, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      // alert_clr together with a bad word: set wins
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'h4018, 1, 1, 1, 1, 0, 2, 1, 1, 0, 0);
      add(16'hC02E, 0, 1, 2, 0, 0, 3, 1, 1, 0, 0);
      add(16'h0000, 1, 0, 0, 0, 1, 3, 1, 0, 0, 0);
      // format error word is not stored
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'h8000, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      add(16'hC02E, 0, 1, 1, 0, 0, 2, 1, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
      // idle timeout after 8 idle words
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) add(16'h0000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      add(16'h0000, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
      // 7 idle words: no timeout
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) add(16'h0000, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'hC02E, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      // overflow: 18 data words + last frame, only 16 stored
      for (int i = 0; i < 16; i++) add(16'h4017, 0, 1, 5'(i), 1, 0, 5'(i + 1), 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) add(16'h4017, 0, 0, 0, 1, 0, 16, 0, 0, 1, 0);
      add(16'hC02E, 0, 0, 0, 0, 0, 16, 0, 0, 1, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 16, 0, 0, 1, 0);
      run();
      // asynchronous reset during the second word of a burst
      word = 16'h4017;
      qa.push_back({5'd0, 16'h4017});
      qb.push_back({5'd16, 16'h4017});
      @(posedge clk);
      @(negedge clk);
      word = 16'h402E;
      @(posedge clk);
      #1 chk("pre_rst_wr_en", 32'(ia.wr_en), 32'd1);
      #1 rst = 1'b1;
      #1 chk("async_rst_st_a", 32'(st_a), 32'd0);
      chk("async_rst_st_b", 32'(st_b), 32'd0);
      chk("async_rst_addr_a", 32'(ia.wr_addr), 32'd0);
      chk("async_rst_data_a", 32'(ia.wr_data), 32'd0);
      @(negedge clk);
      word = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      // clean burst after reset restarts at ADDR_INIT
      add(16'h4017, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      add(16'h402E, 0, 1, 1, 1, 0, 2, 0, 0, 0, 0);
      add(16'hC02E, 0, 1, 2, 0, 0, 3, 0, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
      add(16'h0000, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
      run();
      chk("sb_left_a", 32'(qa.size()), 32'd0);
      chk("sb_left_b", 32'(qb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
